led_ctrl: RTL and testbench
===========================

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LED, default 4: number of LED channels, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 24: blink prescaler width.
REQ-003 SHALL have parameter DATA_W, default 32: operand/threshold width.
REQ-004 SHALL have port CLK, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port RSTn, input, 1: reset, asynchronous active-low.
REQ-006 SHALL have port cfg_wr, input, 1: one-cycle strobe, captures cfg_mode/cfg_period/cfg_thresh/cfg_duty.
REQ-007 SHALL have port cfg_mode, input, 2*NUM_LED: per-channel mode, channel i in bits [2i+1:2i].
REQ-008 SHALL have port cfg_period, input, CNT_W: blink half-period minus one, in CLK cycles.
REQ-009 SHALL have port cfg_thresh, input, DATA_W: compare-mode threshold.
REQ-010 SHALL have port cfg_duty, input, 8: PWM duty (used only with LED_PWM_EN).
REQ-011 SHALL have ports data_a and data_b, input, DATA_W each: operands.
REQ-012 SHALL have port sum_out, output, DATA_W: registered data_a+data_b.
REQ-013 SHALL have port sum_ovf, output, 1: registered carry-out of that sum.
REQ-014 SHALL have port led, output, NUM_LED: LED drive, active-high.
REQ-015 SHALL have port tick, output, 1: one-cycle pulse at each prescaler wrap.

Function
REQ-016 Config registers SHALL load on the CLK edge where cfg_wr=1; outputs use new config from the following cycle.
REQ-017 Prescaler SHALL count 0..period_reg then wrap to 0; tick=1 in the cycle the count equals period_reg.
REQ-018 period_reg=0 SHALL give tick=1 every cycle.
REQ-019 cfg_wr SHALL force the prescaler to 0 on the same edge; tick SHALL NOT assert on that edge.
REQ-020 Mode 00 (OFF): led[i]=0.
REQ-021 Mode 01 (ON): led[i]=1.
REQ-022 Mode 10 (BLINK): led[i] SHALL toggle on each edge where tick=1.
REQ-023 Mode 10: led[i] SHALL restart at 0 whenever cfg_wr writes mode 10 to channel i, even if already 10.
REQ-024 Mode 11 (CMP): led[i]=1 iff data_b registered one cycle earlier is strictly greater than thresh_reg (2-cycle latency input to led); equality gives 0.
REQ-025 All led bits SHALL be registered outputs; no combinational path from inputs to led.
REQ-026 sum_out/sum_ovf SHALL update every cycle with 1-cycle latency; {sum_ovf,sum_out} = data_a+data_b at DATA_W+1 bits, no saturation.

Reset
REQ-027 RSTn=0 SHALL asynchronously clear led, tick, sum_out, sum_ovf, prescaler, blink phases, compare pipeline, all config registers (mode OFF, period 0, thresh 0, duty 0).
REQ-028 RSTn asserted mid-blink or mid-PWM SHALL drop led to 0 immediately; after release, behaviour as after power-up (OFF until cfg_wr).
REQ-029 Release of RSTn SHALL be treated as synchronous to CLK by the instantiating system; the first active edge after release SHALL perform normal operation.

Configuration
REQ-030 Macro LED_PWM_EN defined: free-running 8-bit pwm_cnt (reset 0, wraps 255->0); in ON and in BLINK-high phase led[i]=1 only when pwm_cnt < duty_reg; duty_reg=0 gives constantly 0; CMP and OFF unaffected.
REQ-031 Macro LED_PWM_EN undefined: no pwm_cnt; cfg_duty ignored; ON and BLINK-high give led=1 at full level.

Verification
REQ-032 Reset, cfg_wr mode=all 01 -> led=4'b1111 two edges after strobe; RSTn low mid-run -> led=0 without a CLK edge.
REQ-033 period=3, ch0 mode 10 -> tick every 4 cycles, led[0] toggles every 4 cycles, starts low; period=0 -> toggles every cycle.
REQ-034 ch1 mode 11, thresh=32'hC000_0000; data_b=32'hC000_0000 -> led[1]=0; 32'hC000_0001 -> led[1]=1 two cycles later.
REQ-035 data_a=32'hFFFF_FFFF, data_b=1 -> sum_out=0, sum_ovf=1 next cycle; 5+7 -> 12, ovf=0.
REQ-036 cfg_wr during blink with period change 3->1 -> prescaler restarts at 0, blink phase to 0, toggles every 2 cycles thereafter.
REQ-037 LED_PWM_EN, ch0 ON, duty=64 -> led[0] high 64 of every 256 cycles; duty=0 -> always low; build without macro -> always high.

Source files
------------

// File: rtl/led_ctrl.sv
// LED controller: per-channel OFF/ON/BLINK/CMP modes, blink prescaler and registered adder.
// Define LED_PWM_EN to dim ON and BLINK-high channels with an 8-bit PWM.
module led_ctrl #(
  parameter int NUM_LED = 4,
  parameter int CNT_W   = 24,
  parameter int DATA_W  = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   cfg_wr,
  input  logic [2*NUM_LED-1:0]   cfg_mode,
  input  logic [CNT_W-1:0]       cfg_period,
  input  logic [DATA_W-1:0]      cfg_thresh,
  input  logic [7:0]             cfg_duty,
  input  logic [DATA_W-1:0]      data_a,
  input  logic [DATA_W-1:0]      data_b,
  output logic [DATA_W-1:0]      sum_out,
  output logic                   sum_ovf,
  output logic [NUM_LED-1:0]     led,
  output logic                   tick
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_CMP   = 2'b11;

  logic [2*NUM_LED-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    thresh_q, thresh_d;
  logic [DATA_W-1:0]    datab_q, datab_d;
  logic [NUM_LED-1:0]   phase_q, phase_d;
  logic [NUM_LED-1:0]   led_q, led_d;
  logic                 tick_q, tick_d;
  logic [DATA_W:0]      sum_q, sum_d;
  logic                 cmp_gt;
  logic                 full_on;

`ifdef LED_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    duty_d    = cfg_wr ? cfg_duty : duty_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  assign full_on = (pwm_cnt_q < duty_q);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      duty_q    <= '0;
      pwm_cnt_q <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
  assign full_on     = 1'b1;
`endif

  always_comb begin
    mode_d   = cfg_wr ? cfg_mode   : mode_q;
    period_d = cfg_wr ? cfg_period : period_q;
    thresh_d = cfg_wr ? cfg_thresh : thresh_q;
    datab_d  = data_b;
    sum_d    = {1'b0, data_a} + {1'b0, data_b};
    // A config write restarts the prescaler and suppresses the tick for that cycle.
    if (cfg_wr || (cnt_q >= period_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = !cfg_wr && (cnt_d == period_q);
  end

  assign cmp_gt = (datab_q > thresh_q);

  for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_ch
    logic [1:0] mode_cur;
    logic       blink_wr;

    assign mode_cur = mode_q[2*gi+1 -: 2];
    assign blink_wr = cfg_wr && (cfg_mode[2*gi+1 -: 2] == MODE_BLINK);

    // Blink led follows the next phase so it toggles on the same edge the tick is seen.
    assign phase_d[gi] = blink_wr ? 1'b0 : (phase_q[gi] ^ tick_q);

    assign led_d[gi] = (mode_cur == MODE_ON)    ? full_on :
                       (mode_cur == MODE_BLINK) ? (phase_d[gi] & full_on) :
                       (mode_cur == MODE_CMP)   ? cmp_gt :
                       (mode_cur == MODE_OFF)   ? 1'b0 : 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_q   <= '0;
      period_q <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      datab_q  <= '0;
      phase_q  <= '0;
      led_q    <= '0;
      sum_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      thresh_q <= thresh_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      datab_q  <= datab_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      sum_q    <= sum_d;
    end
  end

  assign led     = led_q;
  assign tick    = tick_q;
  assign sum_out = sum_q[DATA_W-1:0];
  assign sum_ovf = sum_q[DATA_W];

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_led_ctrl;
  localparam int NUM_LED = 4;
  localparam int CNT_W   = 24;
  localparam int DATA_W  = 32;
  localparam int SEL_LED  = 0;
  localparam int SEL_SUM  = 1;
  localparam int SEL_OVF  = 2;
  localparam int SEL_TICK = 3;

  logic                 CLK = 1'b0;
  logic                 RSTn;
  logic                 cfg_wr;
  logic [2*NUM_LED-1:0] cfg_mode;
  logic [CNT_W-1:0]     cfg_period;
  logic [DATA_W-1:0]    cfg_thresh;
  logic [7:0]           cfg_duty;
  logic [DATA_W-1:0]    data_a;
  logic [DATA_W-1:0]    data_b;
  logic [DATA_W-1:0]    sum_out;
  logic                 sum_ovf;
  logic [NUM_LED-1:0]   led;
  logic                 tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [32:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  int rst_led [7] = '{0, 0, 1, 1, 0, 0, 1};
  int rst_tick[6] = '{0, 1, 0, 1, 0, 1};
  int p0_led  [6] = '{0, 0, 1, 0, 1, 0};

  led_ctrl #(.NUM_LED(NUM_LED), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_thresh(cfg_thresh), .cfg_duty(cfg_duty),
    .data_a(data_a), .data_b(data_b), .sum_out(sum_out), .sum_ovf(sum_ovf),
    .led(led), .tick(tick)
  );

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [32:0] observe(int sel);
    case (sel)
      SEL_LED:  return 33'(led);
      SEL_SUM:  return 33'(sum_out);
      SEL_OVF:  return 33'(sum_ovf);
      SEL_TICK: return 33'(tick);
      default:  return '0;
    endcase
  endfunction

  task automatic check(string nm, logic [32:0] act, logic [32:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end else begin
      $display("ok   %s cyc=%0d val=%h", nm, cyc, act);
    end
  endtask

  // Monitor: compare every expectation due in this cycle.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, observe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d got=none want=%h", sb[i].name, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic exp_at(string nm, int sel, logic [32:0] v, int d);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_cfg(logic [7:0] m, logic [23:0] p, logic [31:0] t, logic [7:0] du);
    cfg_mode   = m;
    cfg_period = p;
    cfg_thresh = t;
    cfg_duty   = du;
    cfg_wr     = 1'b1;
    step(1);
    cfg_wr     = 1'b0;
  endtask

  initial begin
    int hi;
    RSTn = 1'b0; cfg_wr = 1'b0; cfg_mode = '0; cfg_period = '0;
    cfg_thresh = '0; cfg_duty = '0; data_a = '0; data_b = '0;
    #2;
    check("rst_led", 33'(led), 33'h0);
    check("rst_tick", 33'(tick), 33'h0);
    check("rst_sum", 33'(sum_out), 33'h0);
    check("rst_ovf", 33'(sum_ovf), 33'h0);
    step(2);
    RSTn = 1'b1;
    exp_at("post_rst_led", SEL_LED, 33'h0, 1);
    exp_at("post_rst_led", SEL_LED, 33'h0, 2);
    step(2);

    // Adder edge cases alongside an all-ON config write.
    data_a = 32'hFFFF_FFFF; data_b = 32'h1;
    exp_at("sum_wrap", SEL_SUM, 33'h0, 1);
    exp_at("ovf_wrap", SEL_OVF, 33'h1, 1);
    exp_at("on_led_d1", SEL_LED, 33'h0, 1);
    exp_at("on_led_d2", SEL_LED, 33'hF, 2);
    do_cfg(8'h55, 24'd0, 32'h0, 8'd0);
    data_a = 32'd5; data_b = 32'd7;
    exp_at("sum_5_7", SEL_SUM, 33'd12, 1);
    exp_at("ovf_5_7", SEL_OVF, 33'h0, 1);
    step(1);
    data_a = 32'h1234_5678; data_b = 32'h1111_1111;
    exp_at("sum_mix", SEL_SUM, 33'h2345_6789, 1);
    exp_at("on_led_d3", SEL_LED, 33'hF, 1);
    step(1);
    data_a = 32'h8000_0000; data_b = 32'h8000_0001;
    exp_at("sum_hi", SEL_SUM, 33'h1, 1);
    exp_at("ovf_hi", SEL_OVF, 33'h1, 1);
    step(3);

    // Asynchronous reset between clock edges.
    #3 RSTn = 1'b0;
    #1;
    check("async_led", 33'(led), 33'h0);
    check("async_sum", 33'(sum_out), 33'h0);
    check("async_ovf", 33'(sum_ovf), 33'h0);
    check("async_tick", 33'(tick), 33'h0);
    step(1);
    RSTn = 1'b1;
    exp_at("rel_sum", SEL_SUM, 33'h1, 1);
    exp_at("rel_ovf", SEL_OVF, 33'h1, 1);
    for (int d = 1; d <= 3; d++) exp_at("rel_led_off", SEL_LED, 33'h0, d);
    step(3);

    // Blink ch0 with period 3.
    data_a = '0; data_b = '0;
    for (int d = 1; d <= 12; d++) begin
      exp_at("blink3_tick", SEL_TICK, 33'((d % 4) == 0), d);
      exp_at("blink3_led", SEL_LED, 33'((d >= 5) && (d <= 8)), d);
    end
    do_cfg(8'h02, 24'd3, 32'h0, 8'd0);
    step(11);

    // Rewrite blink with period 1 on a tick cycle: phase restarts instead of toggling.
    for (int d = 1; d <= 7; d++) exp_at("restart_led", SEL_LED, 33'(rst_led[d-1]), d);
    for (int d = 1; d <= 6; d++) exp_at("restart_tick", SEL_TICK, 33'(rst_tick[d-1]), d);
    do_cfg(8'h02, 24'd1, 32'h0, 8'd0);
    step(6);

    // Period 0: tick every cycle, led toggles every cycle.
    for (int d = 1; d <= 6; d++) begin
      exp_at("p0_led", SEL_LED, 33'(p0_led[d-1]), d);
      exp_at("p0_tick", SEL_TICK, 33'(d >= 2), d);
    end
    do_cfg(8'h02, 24'd0, 32'h0, 8'd0);
    step(5);

    // Compare mode on ch1, strict greater-than with 2-cycle latency.
    do_cfg(8'h0C, 24'd5, 32'hC000_0000, 8'd0);
    exp_at("cmp_zero", SEL_LED, 33'h0, 1);
    data_b = 32'hC000_0000;
    exp_at("cmp_equal", SEL_LED, 33'h0, 2);
    step(1);
    data_b = 32'hC000_0001;
    exp_at("cmp_above", SEL_LED, 33'h2, 2);
    step(1);
    data_b = 32'hFFFF_FFFF;
    exp_at("cmp_max", SEL_LED, 33'h2, 2);
    step(1);
    data_b = 32'h0;
    exp_at("cmp_drop", SEL_LED, 33'h0, 2);
    step(1);
    data_b = 32'h7FFF_FFFF;
    exp_at("cmp_below", SEL_LED, 33'h0, 2);
    step(3);

`ifdef LED_PWM_EN
    do_cfg(8'h01, 24'd0, 32'h0, 8'd64);
    step(4);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      if (led[0]) hi++;
    end
    check("pwm_duty64", 33'(hi), 33'd64);
    do_cfg(8'h01, 24'd0, 32'h0, 8'd0);
    step(4);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      if (led[0]) hi++;
    end
    check("pwm_duty0", 33'(hi), 33'd0);
`else
    hi = 0;
    for (int d = 2; d <= 10; d++) exp_at("on_full", SEL_LED, 33'h1, d);
    do_cfg(8'h01, 24'd0, 32'h0, 8'd64);
    step(9);
`endif

    step(3);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s unchecked cyc=%0d got=none want=%h", sb[i].name, sb[i].cyc, sb[i].val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
